// File: rtl/mult_accumulator.sv
// Group accumulator for the multiplier product bus.
// Unsigned products arrive over a valid/ready handshake and are summed until p_last.
// Each completed group is presented as {sum, beat count, overflow} on a valid/ready port.
module mult_accumulator #(
  parameter int unsigned N      = 32,
  parameter int unsigned PROD_W = 2 * N,
  parameter int unsigned ACC_W  = 2 * N + 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              p_valid_i,
  output logic              p_ready_o,
  input  logic [PROD_W-1:0] p_i,
  input  logic              p_last_i,
  output logic              acc_valid_o,
  input  logic              acc_ready_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic [CNT_W-1:0]  acc_count_o,
  output logic              acc_ovf_o,
  output logic              busy_o
);

  typedef enum logic {StAcc, StHold} state_e;

  state_e             state_q;

  // Running group state; only meaningful while in StAcc.
  logic [ACC_W-1:0]   sum_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;

  // Registered result port.
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   acc_count_q;
  logic               acc_ovf_q;
  logic               acc_valid_q;
  logic               busy_q;

  // Next-state values for an accepted beat.
  logic [ACC_W:0]     sum_ext;
  logic [ACC_W-1:0]   sum_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               ovf_d;
  logic               beat_accept;

  // Accumulate one extra bit so a carry out of the accumulator sets the sticky overflow.
  always_comb begin
    sum_ext = {1'b0, sum_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, p_i};
    sum_d   = sum_ext[ACC_W-1:0];
    ovf_d   = ovf_q | sum_ext[ACC_W];
    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
  end

  // clr wins over the product handshake, so ready drops combinationally with it.
  assign p_ready_o   = (state_q == StAcc) && !clr_i;
  assign beat_accept = p_valid_i && p_ready_o;

  // Two-state accumulate/hold machine with all result outputs registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StAcc;
      sum_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
      acc_count_q <= '0;
      acc_ovf_q   <= 1'b0;
      acc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StAcc: begin
          if (clr_i) begin
            // Drop any partial group; the offered beat is not consumed.
            sum_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
          end else if (beat_accept) begin
            busy_q <= 1'b1;
            if (p_last_i) begin
              state_q     <= StHold;
              acc_q       <= sum_d;
              acc_count_q <= cnt_d;
              acc_ovf_q   <= ovf_d;
              acc_valid_q <= 1'b1;
            end else begin
              sum_q <= sum_d;
              cnt_q <= cnt_d;
              ovf_q <= ovf_d;
            end
          end
        end
        StHold: begin
          // A clear and a transfer leave the same state behind; clr just means no transfer.
          if (clr_i || acc_ready_i) begin
            state_q     <= StAcc;
            sum_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            acc_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= StAcc;
        end
      endcase
    end
  end

  assign acc_o       = acc_q;
  assign acc_count_o = acc_count_q;
  assign acc_ovf_o   = acc_ovf_q;
  assign acc_valid_o = acc_valid_q;
  assign busy_o      = busy_q;

endmodule

// File: doc/mult_accumulator.md
Name: mult_accumulator

Overview:
- Downstream consumer of the Wallace tree multiplier's product bus.
- Accepts unsigned products over a valid/ready handshake and sums them in groups delimited by p_last.
- Each group's sum, beat count and overflow flag are presented on a valid/ready result port.
- Forms the accumulate half of the multiplier's MAC datapath.

Parameters:
N, 32, operand width of the upstream multiplier
PROD_W, 2*N, product width (matches multiplier p bus)
ACC_W, 2*N+8, accumulator width (8 guard bits)
CNT_W, 8, group beat-counter width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
clr  input  1  synchronous clear; discards partial group or held result
p_valid  input  1  product beat valid
p_ready  output  1  block can accept a product beat
p  input  PROD_W  unsigned product from multiplier
p_last  input  1  marks final product of a group
acc_valid  output  1  group result valid
acc_ready  input  1  downstream accepts result
acc  output  ACC_W  group sum, modulo 2^ACC_W
acc_count  output  CNT_W  beats in group, saturating
acc_ovf  output  1  sticky: group sum exceeded 2^ACC_W-1
busy  output  1  partial group in progress or result held

Behaviour:
- Clock and reset: single clock clk; rst asynchronous, active-high. Reset, whether idle or mid-operation, immediately forces:
  - state=ACC; acc=0, acc_count=0, acc_ovf=0, acc_valid=0, busy=0.
  - Any partial sum is lost.
- FSM, two states:
  - ACC: p_ready=!clr, acc_valid=0.
  - HOLD: p_ready=0, acc_valid=1.
- Handshakes:
  - Beat accepted when p_valid&&p_ready.
  - Result transferred when acc_valid&&acc_ready.
- Accepted beat in ACC:
  - Running sum: sum_next = sum + zero_extend(p) at ACC_W+1 bits. Bit ACC_W set ORs into ovf_next. Stored sum = low ACC_W bits (wraps).
  - count_next = count+1, saturating at 2^CNT_W-1.
  - p_last=1: next state HOLD; acc/acc_count/acc_ovf load the updated values. acc_valid rises the cycle after the last beat is accepted (latency 1).
  - p_last=0: stay in ACC, busy=1.
- First beat of a group: the sum starts from 0, so a single-beat group with p_last yields acc=p, acc_count=1.
- HOLD:
  - acc, acc_count and acc_ovf are held stable while acc_ready=0. This holds for arbitrary backpressure.
  - Transfer: next state ACC; internal sum, count and ovf clear to 0; busy=0. No product is accepted in the transfer cycle.
- Throughput: a K-beat group occupies K+1 cycles minimum.
- clr, priority over all handshakes:
  - In ACC: p_ready forced 0 that cycle. Sum, count and ovf clear next cycle; the beat is not consumed.
  - In HOLD: result dropped; acc_valid=0 next cycle; state=ACC. A simultaneous acc_ready is ignored; no transfer counts.
- p_valid with p_ready=0: upstream must hold p and p_last stable. The block does not sample.
- Outputs acc, acc_count and acc_ovf keep their last value in ACC; they are only meaningful when acc_valid=1.
- All outputs are registered except p_ready, which is combinational from state and clr.

Test Plan:
1. N=32, acc_ready=1; beats p=3, 5, 7, with p_last on 7 → acc_valid one cycle after the 7 beat; acc=15, acc_count=3, acc_ovf=0; busy=0 the cycle after transfer.
2. N=4, ACC_W=10; five beats p=225, last on the fifth → acc=101 (1125-1024), acc_ovf=1, acc_count=5. The next group of {1 last} gives acc=1, acc_ovf=0 (sticky cleared per group).
3. Single beat p=0xFFFF_FFFE_0000_0001 with p_last → acc=zero-extended value, acc_count=1. Hold acc_ready=0 for 6 cycles → acc_valid=1, outputs constant, p_ready=0 for all 6 cycles, then transfer on acc_ready=1.
4. Beats 10, 20 (no last), then rst pulsed asynchronously mid-cycle → outputs zero immediately. Next group {4 last} gives acc=4, acc_count=1.
5. Beats 10, 20, then clr with p_valid=1, p=99 → p_ready=0, 99 not consumed. Next group {1, 2 last} gives acc=3, acc_count=2. Separately: clr during HOLD with acc_ready=1 → no transfer, acc_valid=0 next cycle.
6. CNT_W=2, N=4; group of 5 beats of p=1 → acc=5, acc_count=3 (saturated), acc_ovf=0.
